// File: rtl/mem_access_unit.sv
// Load/store initiator between the CPU MEM stage and a handshaked word-wide data memory.
// Optional feature macro: MEM_ALIGN_CHECK_EN (rejects misaligned half/word accesses).
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_type,
  input  logic        cpu_unsigned,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [2:0] T_WORD = 3'b000;
  localparam logic [2:0] T_HALF = 3'b001;
  localparam logic [2:0] T_BYTE = 3'b010;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t      state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]  lat_type, lat_type_nx;
  logic [1:0]  lat_off, lat_off_nx;
  logic        lat_uns, lat_uns_nx;
  logic        cpu_done_nx, cpu_err_nx;
  logic [31:0] cpu_rdata_nx;
  logic        mem_req_nx, mem_we_nx;
  logic [31:0] mem_addr_nx, mem_wdata_nx;
  logic [3:0]  mem_be_nx;
  logic        type_bad, align_bad, timeout_hit;

  function automatic logic [3:0] be_of(input logic [2:0] t, input logic [1:0] off);
    case (t)
      T_HALF:  be_of = off[1] ? 4'b1100 : 4'b0011;
      T_BYTE:  be_of = 4'b0001 << off;
      default: be_of = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_of(input logic [2:0] t, input logic [31:0] d);
    case (t)
      T_HALF:  wdata_of = {2{d[15:0]}};
      T_BYTE:  wdata_of = {4{d[7:0]}};
      default: wdata_of = d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] t, input logic uns,
                                           input logic [1:0] off, input logic [31:0] d);
    logic [15:0] h;
    logic [7:0]  b;
    h = off[1] ? d[31:16] : d[15:0];
    case (off)
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      2'd3:    b = d[31:24];
      default: b = d[7:0];
    endcase
    case (t)
      T_HALF:  load_ext = {{16{h[15] & ~uns}}, h};
      T_BYTE:  load_ext = {{24{b[7] & ~uns}}, b};
      default: load_ext = d;
    endcase
  endfunction

  assign type_bad = (cpu_type != T_WORD) && (cpu_type != T_HALF) && (cpu_type != T_BYTE);
`ifdef MEM_ALIGN_CHECK_EN
  assign align_bad = ((cpu_type == T_HALF) && cpu_addr[0]) ||
                     ((cpu_type == T_WORD) && (cpu_addr[1:0] != 2'b00));
`else
  assign align_bad = 1'b0;
`endif
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

  // Stall is the only combinational output; forced low while reset is held.
  assign cpu_stall = reset && (((state == S_IDLE) && cpu_req) || (state == S_REQ));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      lat_type  <= '0;
      lat_off   <= '0;
      lat_uns   <= 1'b0;
      cpu_done  <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      lat_type  <= lat_type_nx;
      lat_off   <= lat_off_nx;
      lat_uns   <= lat_uns_nx;
      cpu_done  <= cpu_done_nx;
      cpu_err   <= cpu_err_nx;
      cpu_rdata <= cpu_rdata_nx;
      mem_req   <= mem_req_nx;
      mem_we    <= mem_we_nx;
      mem_addr  <= mem_addr_nx;
      mem_be    <= mem_be_nx;
      mem_wdata <= mem_wdata_nx;
    end
  end

  // Next-state and next-output logic; outputs hold unless a transition updates them.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    lat_type_nx  = lat_type;
    lat_off_nx   = lat_off;
    lat_uns_nx   = lat_uns;
    cpu_done_nx  = 1'b0;
    cpu_err_nx   = cpu_err;
    cpu_rdata_nx = cpu_rdata;
    mem_req_nx   = mem_req;
    mem_we_nx    = mem_we;
    mem_addr_nx  = mem_addr;
    mem_be_nx    = mem_be;
    mem_wdata_nx = mem_wdata;
    case (state)
      S_IDLE: begin
        cnt_nx = '0;
        if (cpu_req) begin
          lat_type_nx  = cpu_type;
          lat_off_nx   = cpu_addr[1:0];
          lat_uns_nx   = cpu_unsigned;
          mem_we_nx    = cpu_we;
          mem_addr_nx  = {cpu_addr[31:2], 2'b00};
          mem_be_nx    = be_of(cpu_type, cpu_addr[1:0]);
          mem_wdata_nx = wdata_of(cpu_type, cpu_wdata);
          if (type_bad || align_bad) begin
            state_nx     = S_DONE;
            cpu_done_nx  = 1'b1;
            cpu_err_nx   = 1'b1;
            cpu_rdata_nx = '0;
          end else begin
            state_nx   = S_REQ;
            mem_req_nx = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          state_nx     = S_DONE;
          mem_req_nx   = 1'b0;
          cnt_nx       = '0;
          cpu_done_nx  = 1'b1;
          cpu_err_nx   = 1'b0;
          cpu_rdata_nx = mem_we ? '0 : load_ext(lat_type, lat_uns, lat_off, mem_rdata);
        end else if (timeout_hit) begin
          state_nx     = S_DONE;
          mem_req_nx   = 1'b0;
          cnt_nx       = '0;
          cpu_done_nx  = 1'b1;
          cpu_err_nx   = 1'b1;
          cpu_rdata_nx = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx   = S_IDLE;
        mem_req_nx = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: driver pushes expected memory requests and
// CPU completions; a negedge monitor pops and compares as the DUT presents them.
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_unsigned;
  logic [2:0]  cpu_type;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_stall, cpu_done, cpu_err;
  logic [31:0] cpu_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_type(cpu_type), .cpu_unsigned(cpu_unsigned),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          cycles;
  } mem_exp_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cycles;
    int          issue;
  } cpu_exp_t;

  mem_exp_t mq[$];
  cpu_exp_t cq[$];

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int ack_delay = 0;
  logic [31:0] rdata_val = '0;
  logic late_ack = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory responder: acks on the ack_delay-th consecutive mem_req cycle (0 = never).
  int rlen = 0;
  always @(negedge clk) begin
    if (mem_req) begin
      rlen++;
      mem_ack = ((ack_delay > 0) && (rlen == ack_delay)) || late_ack;
    end else begin
      rlen = 0;
      mem_ack = late_ack;
    end
    mem_rdata = rdata_val;
  end

  // Monitor: compares presented requests/completions against the scoreboard queues.
  int       mlen = 0;
  bit       have = 1'b0;
  mem_exp_t cur;
  cpu_exp_t ce;
  always @(negedge clk) begin
    if (mem_req) begin
      if (mlen == 0) begin
        if (mq.size() == 0) begin
          n_checks++; n_fails++; have = 1'b0;
          $display("FAIL unexpected_mem_req: addr 0x%08h with no request expected", mem_addr);
        end else begin
          cur = mq.pop_front();
          have = 1'b1;
        end
      end
      mlen++;
      if (have) begin
        chk("mem_we", 32'(mem_we), 32'(cur.we));
        chk("mem_addr", mem_addr, cur.addr);
        chk("mem_be", 32'(mem_be), 32'(cur.be));
        if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
      end
      chk("stall_in_req", 32'(cpu_stall), 32'd1);
    end else begin
      if (mlen != 0 && have) chk("mem_req_cycles", 32'(mlen), 32'(cur.cycles));
      mlen = 0;
      have = 1'b0;
    end
    if (cpu_done) begin
      if (cq.size() == 0) begin
        n_checks++; n_fails++;
        $display("FAIL unexpected_cpu_done: err %0b rdata 0x%08h", cpu_err, cpu_rdata);
      end else begin
        ce = cq.pop_front();
        chk("cpu_err", 32'(cpu_err), 32'(ce.err));
        chk("cpu_rdata", cpu_rdata, ce.rdata);
        chk("done_latency", 32'(cyc - ce.issue), 32'(ce.cycles + 1));
        chk("stall_in_done", 32'(cpu_stall), 32'd0);
      end
    end
  end

  task automatic access(input logic we, input logic [2:0] typ, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int d, input logic [31:0] rd, input bit has_mem,
                        input logic [3:0] be, input logic [31:0] exp_wdata, input int req_cycles,
                        input logic err, input logic [31:0] exp_rdata);
    mem_exp_t m;
    cpu_exp_t c;
    bit got;
    @(negedge clk);
    if (has_mem) begin
      m.we = we; m.addr = {addr[31:2], 2'b00}; m.be = be; m.wdata = exp_wdata;
      m.cycles = req_cycles;
      mq.push_back(m);
    end
    c.err = err; c.rdata = exp_rdata; c.cycles = req_cycles; c.issue = cyc;
    cq.push_back(c);
    ack_delay = d;
    rdata_val = rd;
    cpu_req = 1'b1; cpu_we = we; cpu_type = typ; cpu_unsigned = uns;
    cpu_addr = addr; cpu_wdata = wdata;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cpu_done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_checks++; n_fails++;
      $display("FAIL done_wait: no cpu_done within 40 cycles for addr 0x%08h", addr);
    end
    cpu_req = 1'b0;
  endtask

  localparam logic [31:0] RD = 32'h8001F234;

  initial begin
    reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_type = 3'b000; cpu_unsigned = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_cpu_done", 32'(cpu_done), 32'd0);
    chk("rst_cpu_err", 32'(cpu_err), 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
    reset = 1'b1;

    // Loads of 0x8001F234 with sign/zero extension
    access(0, 3'b001, 0, 32'h02, 0, 1, RD, 1, 4'b1100, 0, 1, 0, 32'hFFFF8001);
    access(0, 3'b001, 1, 32'h02, 0, 1, RD, 1, 4'b1100, 0, 1, 0, 32'h00008001);
    access(0, 3'b010, 0, 32'h01, 0, 2, RD, 1, 4'b0010, 0, 2, 0, 32'hFFFFFFF2);
    access(0, 3'b010, 1, 32'h00, 0, 1, RD, 1, 4'b0001, 0, 1, 0, 32'h00000034);
    access(0, 3'b000, 1, 32'h00, 0, 1, RD, 1, 4'b1111, 0, 1, 0, 32'h8001F234);
    access(0, 3'b010, 0, 32'h03, 0, 1, RD, 1, 4'b1000, 0, 1, 0, 32'hFFFFFF80);
    access(0, 3'b001, 1, 32'h00, 0, 1, RD, 1, 4'b0011, 0, 1, 0, 32'h0000F234);

    // Stores: lane replication, byte enables, cpu_rdata cleared
    access(1, 3'b000, 0, 32'h10, 32'h12345678, 3, RD, 1, 4'b1111, 32'h12345678, 3, 0, 0);
    access(1, 3'b010, 0, 32'h13, 32'h000000AB, 1, RD, 1, 4'b1000, 32'hABABABAB, 1, 0, 0);
    access(1, 3'b001, 0, 32'h02, 32'h1234BEEF, 2, RD, 1, 4'b1100, 32'hBEEFBEEF, 2, 0, 0);

    // Invalid type: no memory request, immediate error completion
    access(0, 3'b011, 0, 32'h40, 0, 1, RD, 0, 4'b0000, 0, 0, 1, 0);
    access(1, 3'b111, 0, 32'h44, 32'hFFFFFFFF, 1, RD, 0, 4'b0000, 0, 0, 1, 0);

    // Timeout after 4 unacked cycles; ack in the abort cycle wins
    access(0, 3'b000, 0, 32'h20, 0, 0, RD, 1, 4'b1111, 0, 4, 1, 0);
    access(0, 3'b000, 0, 32'h24, 0, 4, 32'hCAFE0001, 1, 4'b1111, 0, 4, 0, 32'hCAFE0001);

    // Misaligned word
`ifdef MEM_ALIGN_CHECK_EN
    access(0, 3'b000, 0, 32'h06, 0, 1, RD, 0, 4'b1111, 0, 0, 1, 0);
`else
    access(0, 3'b000, 0, 32'h06, 0, 1, RD, 1, 4'b1111, 0, 1, 0, RD);
`endif

    // Reset asserted mid-request; a late ack afterwards must be ignored
    begin
      mem_exp_t m;
      @(negedge clk);
      m.we = 1'b0; m.addr = 32'h30; m.be = 4'b1111; m.wdata = '0; m.cycles = 2;
      mq.push_back(m);
      ack_delay = 0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_type = 3'b000; cpu_addr = 32'h30;
      repeat (2) @(negedge clk);
      #2 reset = 1'b0; cpu_req = 1'b0;
      #1;
      chk("rstreq_mem_req", 32'(mem_req), 32'd0);
      chk("rstreq_cpu_stall", 32'(cpu_stall), 32'd0);
      chk("rstreq_cpu_done", 32'(cpu_done), 32'd0);
      chk("rstreq_mem_addr", mem_addr, 32'd0);
      chk("rstreq_mem_be", 32'(mem_be), 32'd0);
      late_ack = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      late_ack = 1'b0;
      chk("postrst_cpu_done", 32'(cpu_done), 32'd0);
      chk("postrst_cpu_rdata", cpu_rdata, 32'd0);
    end

    // Normal operation after reset
    access(0, 3'b010, 1, 32'h02, 0, 1, RD, 1, 4'b0100, 0, 1, 0, 32'h00000001);

    repeat (4) @(negedge clk);
    chk("mem_queue_empty", 32'(mq.size()), 32'd0);
    chk("cpu_queue_empty", 32'(cq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
